mppt_po_tracker: RTL and testbench

//  Parametrised perturb-and-observe MPPT controller. Samples PV voltage/current on a valid strobe,

---
 rtl/mppt_pkg.sv | 26 ++
 rtl/mppt_power_mult.sv | 26 ++
 rtl/mppt_po_tracker.sv | 184 ++++++++++++++++++
 tb/tb_mppt_po_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mppt_pkg.sv
// Shared types and helpers for the perturb-and-observe MPPT tracker.
package mppt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_MULT    = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_UPDATE  = 3'd5
  } state_t;

  // Consecutive same-direction moves before the step is allowed to grow.
  localparam int RUN_LEN = 4;

  // Evaluated on a signed 32-bit value so that duty +/- step can never wrap.
  function automatic int sat_clamp(input int val, input int lo, input int hi);
    if (val < lo) begin
      return lo;
    end else if (val > hi) begin
      return hi;
    end
    return val;
  endfunction

endpackage

// File: rtl/mppt_power_mult.sv
// One-stage registered unsigned multiplier producing the full-width PV power.
module mppt_power_mult #(
  parameter int VW = 16,
  parameter int IW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [VW-1:0]      i_a,
  input  logic [IW-1:0]      i_b,
  output logic [VW+IW-1:0]   o_p
);

  logic [VW+IW-1:0] r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= (VW+IW)'(i_a) * (VW+IW)'(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/mppt_po_tracker.sv
// Perturb-and-observe MPPT controller: hill-climbs the converter duty on registered PV power.
// sample_valid is a one-way strobe with no ready: a sample is used only while the FSM is listening.
module mppt_po_tracker
  import mppt_pkg::*;
#(
  parameter int VW       = 16,
  parameter int IW       = 16,
  parameter int DW       = 10,
  parameter int DMIN     = 32,
  parameter int DMAX     = 992,
  parameter int DINIT    = 512,
  parameter int STEP_MAX = 16,
  parameter int STEP_MIN = 1,
  parameter int ADAPT    = 1,
  parameter int SETTLE   = 8,
  parameter int PDEAD    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sample_valid,
  input  logic [VW-1:0]      v_in,
  input  logic [IW-1:0]      i_in,
  output logic [DW-1:0]      duty_out,
  output logic               duty_valid,
  output logic               at_limit,
  output logic [VW+IW-1:0]   power_out,
  output logic [2:0]         o_dbg_state
);

  localparam int PW = VW + IW;
  localparam logic [DW-1:0]       DMIN_W     = DW'(DMIN);
  localparam logic [DW-1:0]       DMAX_W     = DW'(DMAX);
  localparam logic [DW-1:0]       DINIT_W    = DW'(DINIT);
  localparam logic [DW-1:0]       STEP_MAX_W = DW'(STEP_MAX);
  localparam logic [DW:0]         STEP_MAX_X = (DW+1)'(STEP_MAX);
  localparam logic [DW-1:0]       STEP_MIN_W = DW'(STEP_MIN);
  localparam logic [15:0]         SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [2:0]          RUN_LAST   = 3'(RUN_LEN - 1);
  localparam logic signed [PW:0]  PDEAD_S    = $signed((PW+1)'(PDEAD));

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_settle_cnt;
  logic [VW-1:0]     r_v;
  logic [IW-1:0]     r_i;
  logic [PW-1:0]     r_p_prev;
  logic              r_have_base;
  logic              r_dir_up;
  logic [DW-1:0]     r_step;
  logic [2:0]        r_run_cnt;
  logic [DW-1:0]     r_duty;
  logic              r_duty_valid;
  logic              r_at_limit;

  logic [PW-1:0]     w_power;
  logic signed [PW:0] w_dp;
  logic              w_rise;
  logic              w_fall;
  logic              w_dir_nxt;
  logic [DW-1:0]     w_step_nxt;
  logic [2:0]        w_run_nxt;
  logic [DW-1:0]     w_half;
  logic [DW:0]       w_dbl;
  logic [DW-1:0]     w_target;

  mppt_power_mult #(
    .VW (VW),
    .IW (IW)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state == ST_MULT && en),
    .i_a   (r_v),
    .i_b   (r_i),
    .o_p   (w_power)
  );

  assign w_dp   = $signed({1'b0, w_power}) - $signed({1'b0, r_p_prev});
  assign w_rise = (w_dp > PDEAD_S);
  assign w_fall = (w_dp < -PDEAD_S);
  assign w_half = r_step >> 1;
  assign w_dbl  = {r_step, 1'b0};

  assign w_target = DW'(sat_clamp(r_dir_up ? int'(r_duty) + int'(r_step)
                                           : int'(r_duty) - int'(r_step),
                                  DMIN, DMAX));

  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = ST_SETTLE;
        ST_SETTLE:  if (sample_valid && r_settle_cnt == SETTLE_LAST) w_next = ST_MEASURE;
        ST_MEASURE: if (sample_valid) w_next = ST_MULT;
        ST_MULT:    w_next = ST_DECIDE;
        ST_DECIDE:  w_next = (r_have_base && (w_rise || w_fall)) ? ST_UPDATE : ST_SETTLE;
        ST_UPDATE:  w_next = ST_SETTLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // A reversal halves the step; a full run of same-direction moves doubles it.
  always_comb begin
    w_dir_nxt  = r_dir_up;
    w_step_nxt = r_step;
    w_run_nxt  = r_run_cnt;
    if (w_fall) begin
      w_dir_nxt = ~r_dir_up;
      w_run_nxt = '0;
      if (ADAPT != 0) w_step_nxt = (w_half < STEP_MIN_W) ? STEP_MIN_W : w_half;
    end else if (w_rise) begin
      if (r_run_cnt == RUN_LAST) begin
        w_run_nxt = '0;
        if (ADAPT != 0) w_step_nxt = (w_dbl > STEP_MAX_X) ? STEP_MAX_W : w_dbl[DW-1:0];
      end else begin
        w_run_nxt = r_run_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_v          <= '0;
      r_i          <= '0;
      r_p_prev     <= '0;
      r_have_base  <= 1'b0;
      r_dir_up     <= 1'b1;
      r_step       <= STEP_MAX_W;
      r_run_cnt    <= '0;
      r_duty       <= DINIT_W;
      r_duty_valid <= 1'b0;
      r_at_limit   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_duty_valid <= 1'b0;

      if (r_state != ST_SETTLE) begin
        r_settle_cnt <= '0;
      end else if (en && sample_valid) begin
        r_settle_cnt <= (r_settle_cnt == SETTLE_LAST) ? 16'd0 : r_settle_cnt + 16'd1;
      end

      if (r_state == ST_IDLE) begin
        r_have_base <= 1'b0;
      end

      if (r_state == ST_MEASURE && en && sample_valid) begin
        r_v <= v_in;
        r_i <= i_in;
      end

      // The first decision after enable only records a baseline power.
      if (r_state == ST_DECIDE && en) begin
        r_p_prev <= w_power;
        if (!r_have_base) begin
          r_have_base <= 1'b1;
        end else begin
          r_dir_up  <= w_dir_nxt;
          r_step    <= w_step_nxt;
          r_run_cnt <= w_run_nxt;
        end
      end

      if (r_state == ST_UPDATE && en) begin
        r_duty       <= w_target;
        r_duty_valid <= 1'b1;
        r_at_limit   <= (w_target == DMIN_W) || (w_target == DMAX_W);
      end
    end
  end

  assign duty_out    = r_duty;
  assign duty_valid  = r_duty_valid;
  assign at_limit    = r_at_limit;
  assign power_out   = w_power;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mppt_po_tracker.sv
// Randomised bench for mppt_po_tracker against a transaction-level P&O reference model.
module tb_mppt_po_tracker;

  localparam int VW       = 16;
  localparam int IW       = 16;
  localparam int DW       = 10;
  localparam int DMIN     = 32;
  localparam int DMAX     = 992;
  localparam int DINIT    = 512;
  localparam int STEP_MAX = 16;
  localparam int STEP_MIN = 1;
  localparam int SETTLE   = 8;
  localparam int PDEAD    = 0;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               en;
  logic               sample_valid;
  logic [VW-1:0]      v_in;
  logic [IW-1:0]      i_in;
  logic [DW-1:0]      duty_out;
  logic               duty_valid;
  logic               at_limit;
  logic [VW+IW-1:0]   power_out;
  logic [2:0]         dbg_state;

  mppt_po_tracker #(
    .VW(VW), .IW(IW), .DW(DW), .DMIN(DMIN), .DMAX(DMAX), .DINIT(DINIT),
    .STEP_MAX(STEP_MAX), .STEP_MIN(STEP_MIN), .ADAPT(1), .SETTLE(SETTLE), .PDEAD(PDEAD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_valid (sample_valid),
    .v_in         (v_in),
    .i_in         (i_in),
    .duty_out     (duty_out),
    .duty_valid   (duty_valid),
    .at_limit     (at_limit),
    .power_out    (power_out),
    .o_dbg_state  (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // reference model: one call per accepted measurement
  int     m_duty, m_step, m_run;
  bit     m_up, m_have_base, m_at;
  longint m_pprev;
  logic [VW-1:0] last_v;
  logic [IW-1:0] last_i;

  task automatic model_reset();
    m_duty = DINIT; m_step = STEP_MAX; m_run = 0;
    m_up = 1'b1; m_have_base = 1'b0; m_at = 1'b0; m_pprev = 0;
  endtask

  task automatic model_decide(input longint p, output bit move);
    longint dp;
    int tgt;
    move = 1'b0;
    if (!m_have_base) begin
      m_have_base = 1'b1;
      m_pprev = p;
      return;
    end
    dp = p - m_pprev;
    m_pprev = p;
    if (dp > PDEAD) begin
      move = 1'b1;
      m_run++;
      if (m_run == 4) begin
        m_step = (m_step * 2 > STEP_MAX) ? STEP_MAX : m_step * 2;
        m_run = 0;
      end
    end else if (dp < -PDEAD) begin
      move = 1'b1;
      m_up = !m_up;
      m_step = (m_step / 2 < STEP_MIN) ? STEP_MIN : m_step / 2;
      m_run = 0;
    end
    if (move) begin
      tgt = m_up ? m_duty + m_step : m_duty - m_step;
      if (tgt < DMIN) tgt = DMIN;
      if (tgt > DMAX) tgt = DMAX;
      m_duty = tgt;
      m_at = (tgt == DMIN) || (tgt == DMAX);
    end
  endtask

  // scoreboard: every duty_valid pulse must match the next predicted duty
  always @(negedge clk) begin
    if (rst_n === 1'b1 && duty_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("sb_extra_pulse", 64'(duty_valid), 64'd0);
      else check_eq("sb_duty", 64'(duty_out), exp_q.pop_front());
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
      v_in = VW'($urandom);
      i_in = IW'($urandom);
    end
  endtask

  task automatic send(input logic [VW-1:0] v, input logic [IW-1:0] i);
    @(negedge clk);
    sample_valid = 1'b1;
    v_in = v;
    i_in = i;
  endtask

  task automatic settle_phase();
    for (int k = 0; k < SETTLE; k++) begin
      idle_cyc($urandom_range(0, 2));
      send(VW'($urandom), IW'($urandom));
    end
    idle_cyc($urandom_range(0, 2));
  endtask

  // mode 0: normal, 1: drop en during MULT, 2: reset during UPDATE
  task automatic measure(input logic [VW-1:0] v, input logic [IW-1:0] i, input int mode);
    logic [63:0] p;
    bit mv;
    last_v = v;
    last_i = i;
    settle_phase();
    send(v, i);
    p = 64'(v) * 64'(i);
    @(negedge clk);
    sample_valid = 1'($urandom_range(0, 1));
    v_in = VW'($urandom);
    i_in = IW'($urandom);
    if (mode == 1) begin
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check_eq("en_off_dv", 64'(duty_valid), 64'd0);
        check_eq("en_off_duty", 64'(duty_out), 64'(m_duty));
        sample_valid = 1'($urandom_range(0, 1));
        v_in = VW'($urandom);
        i_in = IW'($urandom);
      end
      @(negedge clk);
      en = 1'b1;
      sample_valid = 1'b0;
      m_have_base = 1'b0;
      return;
    end
    @(negedge clk);
    check_eq("power", 64'(power_out), p);
    sample_valid = 1'($urandom_range(0, 1));
    v_in = VW'($urandom);
    i_in = IW'($urandom);
    @(negedge clk);
    sample_valid = 1'b0;
    check_eq("dv_early", 64'(duty_valid), 64'd0);
    model_decide(longint'(p), mv);
    if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      check_eq("rst_duty", 64'(duty_out), 64'd512);
      check_eq("rst_dv", 64'(duty_valid), 64'd0);
      check_eq("rst_lim", 64'(at_limit), 64'd0);
      check_eq("rst_pwr", 64'(power_out), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    if (mv) exp_q.push_back(64'(m_duty));
    @(negedge clk);
    check_eq("dv", 64'(duty_valid), 64'(mv));
    check_eq("duty", 64'(duty_out), 64'(m_duty));
    check_eq("at_limit", 64'(at_limit), 64'(m_at));
    check_eq("power_hold", 64'(power_out), p);
    sample_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; v_in = '0; i_in = '0;
    last_v = '0; last_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("init_duty", 64'(duty_out), 64'd512);
    check_eq("init_dv", 64'(duty_valid), 64'd0);
    check_eq("init_lim", 64'(at_limit), 64'd0);
    check_eq("init_pwr", 64'(power_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // baseline then holds on constant power
    for (int k = 0; k < 3; k++) measure(16'd100, 16'd50, 0);
    check_eq("base_hold", 64'(duty_out), 64'd512);

    // climb with rising power
    for (int k = 1; k <= 4; k++) measure(16'(100 + 10 * k), 16'd50, 0);
    check_eq("climb_576", 64'(duty_out), 64'd576);

    // reversals
    measure(16'd130, 16'd50, 0);
    check_eq("rev_568", 64'(duty_out), 64'd568);
    measure(16'd120, 16'd50, 0);
    check_eq("rev_572", 64'(duty_out), 64'd572);

    // enable dropped in MULT, then baseline must be re-acquired
    measure(16'd200, 16'd50, 1);
    measure(16'd50, 16'd50, 0);
    check_eq("reen_base", 64'(duty_out), 64'd572);

    // reset in the middle of an UPDATE
    measure(16'd60, 16'd50, 2);

    // drive into the upper clamp, including a full-width product
    measure(16'd1000, 16'd1000, 0);
    for (int k = 1; k <= 40; k++) measure(16'(1000 + 10 * k), 16'd1000, 0);
    check_eq("clamp_hi", 64'(duty_out), 64'd992);
    check_eq("clamp_hi_lim", 64'(at_limit), 64'd1);
    measure(16'hFFFF, 16'hFFFF, 0);

    // reverse and climb the power curve downwards into the lower clamp
    measure(16'd1000, 16'd1000, 0);
    for (int k = 1; k <= 70; k++) measure(16'(1000 + 10 * k), 16'd1000, 0);
    check_eq("clamp_lo", 64'(duty_out), 64'd32);
    check_eq("clamp_lo_lim", 64'(at_limit), 64'd1);

    // random operating points
    for (int k = 0; k < 80; k++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) measure(VW'($urandom), IW'($urandom), 1);
      else if (sel < 6) measure(last_v, last_i, 0);
      else measure(VW'($urandom), IW'($urandom), 0);
    end

    idle_cyc(5);
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
